lcd_cmd_sched: RTL
==================

# lcd_cmd_sched

Command scheduler in front of the LCD_CTRL image-processing core. Two independent command sources (host sequencer and test/debug port) each push 4-bit LCD commands into a private queue. The block round-robins between the queues and issues one command at a time to LCD_CTRL under its `cmd`/`cmd_valid`/`busy` handshake. A Write command (0x0) is terminal: after it is issued, the block waits for LCD_CTRL `done` and then latches completion.

## Interface
- `FIFO_DEPTH`, 4: entries per requester queue; power of two, ≥2.
- `CMD_W`, 4: command width; fixed by LCD_CTRL.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `req0_valid` in 1: requester 0 offers a command.
- `req0_cmd` in CMD_W: requester 0 command.
- `req0_ready` out 1: queue 0 accepts; transfer on `valid & ready` at a rising edge.
- `req1_valid`, `req1_cmd`, `req1_ready`: same as requester 0, for requester 1.
- `lcd_cmd` out CMD_W: command to LCD_CTRL.
- `lcd_cmd_valid` out 1: one-cycle issue strobe.
- `lcd_busy` in 1: LCD_CTRL busy.
- `lcd_done` in 1: LCD_CTRL finished Write.
- `sched_done` out 1: sticky completion flag.
- `err_illegal` out 1: one-cycle pulse when an enqueued command exceeds 0xB.

## Operation
- Legal commands 0x0–0xB:
  - 0 Write; 1–4 shift up/down/left/right; 5 Max; 6 Min; 7 Average.
  - 8 rotate CCW; 9 rotate CW; A mirror X; B mirror Y.
- Illegal commands (0xC–0xF) are consumed (ready stays high), not stored, and pulse `err_illegal` on the next cycle. If both requesters present illegal commands in the same cycle, a single pulse is raised.
- `reqN_ready` = queue N not full AND state ∈ {IDLE, GUARD}. It is computed from the registered occupancy, with no same-cycle pop bypass: a full queue that is popped this cycle still shows ready low.
- Arbitration:
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - When both queues are non-empty, grant the queue ≠ `last_grant`; when one is non-empty, grant it.
  - `last_grant` updates on every issue.
- FSM states IDLE, GUARD, WAIT_DONE, FIN:
  - IDLE: if any queue is non-empty and `lcd_busy`=0, pop the granted head, register `lcd_cmd`, and set `lcd_cmd_valid`=1. Go to GUARD (non-Write) or WAIT_DONE (Write). Otherwise hold.
  - GUARD: `lcd_cmd_valid`←0; go to IDLE next edge. This covers LCD_CTRL's busy-rise latency.
  - WAIT_DONE: `lcd_cmd_valid`←0; queues frozen, ready low; on `lcd_done`=1 go to FIN.
  - FIN: `sched_done`=1, ready low, nothing issued. Entries left in the queues are never issued. Exit only via reset.
- Enqueue and pop on the same queue in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values: `req0_ready`=`req1_ready`=1, `lcd_cmd`=0, `lcd_cmd_valid`=0, `sched_done`=0, `err_illegal`=0; queues empty, state IDLE.
- All outputs are registered, except `reqN_ready`, which is decoded from registers only.
- Latency: a command accepted at edge N into an empty queue, with the block idle and `lcd_busy`=0, gives `lcd_cmd_valid` high from edge N+1 to N+2.
- Minimum spacing between issues is 2 cycles; a further issue waits for `lcd_busy` to be low while in IDLE.
- `sched_done` rises on the edge after `lcd_done` is sampled in WAIT_DONE. `lcd_done` outside WAIT_DONE is ignored.
- Reset mid-operation: every output takes its reset value immediately (asynchronous), and queue contents are discarded.

## Structure
- Shared package `lcd_pkg`: command enum (CMD_WRITE … CMD_MIRROR_Y), `CMD_W`, `CMD_MAX`=4'hB, state enum.
- Sub-module `lcd_cmd_fifo` (synchronous, depth `FIFO_DEPTH`, count-based full/empty), instantiated once per requester.
- The arbiter and FSM live in the top module.

## Test plan
- Single path: reset, req0 pushes 0x3 with `lcd_busy`=0 → `lcd_cmd`=0x3 and `lcd_cmd_valid` one cycle high at edge N+1; the next issue waits until `lcd_busy` falls.
- Round-robin: req0 queues 1,2 and req1 queues 5,6 before the first issue → issue order 1,5,2,6.
- Backpressure: hold `lcd_busy`=1 and push 5 entries on req0 → `req0_ready` low after the 4th; the 5th is accepted after the first pop.
- Illegal command: req1 pushes 0xE → not issued, `err_illegal` pulses once, `req1_ready` stays high.
- Terminal Write: queue 7, 0, 9 on req0 → 7 and 0 are issued, 9 is never issued; `sched_done` rises one cycle after the `lcd_done` pulse, with both readies low.
- Async reset in WAIT_DONE: drop `reset` mid-cycle → outputs take reset values immediately; after release, a fresh command is issued normally.

Source files
------------

// File: rtl/lcd_cmd_sched_pkg.sv
// Shared types for the LCD_CTRL command scheduler: command codes, widths, FSM states.
package lcd_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE    = 4'h0,
    CMD_SHIFT_UP = 4'h1,
    CMD_SHIFT_DN = 4'h2,
    CMD_SHIFT_LT = 4'h3,
    CMD_SHIFT_RT = 4'h4,
    CMD_MAX_OP   = 4'h5,
    CMD_MIN_OP   = 4'h6,
    CMD_AVERAGE  = 4'h7,
    CMD_ROT_CCW  = 4'h8,
    CMD_ROT_CW   = 4'h9,
    CMD_MIRROR_X = 4'hA,
    CMD_MIRROR_Y = 4'hB
  } lcd_cmd_e;

  localparam logic [CMD_W-1:0] CMD_MAX = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_WAIT_DONE,
    ST_FIN
  } sched_state_e;

  function automatic logic cmd_legal(input logic [CMD_W-1:0] c);
    return c <= CMD_MAX;
  endfunction

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// Requester handshakes plus the LCD_CTRL issue port of the command scheduler.
interface lcd_cmd_sched_if;

  logic                      req0_valid;
  logic [lcd_pkg::CMD_W-1:0] req0_cmd;
  logic                      req0_ready;
  logic                      req1_valid;
  logic [lcd_pkg::CMD_W-1:0] req1_cmd;
  logic                      req1_ready;
  logic [lcd_pkg::CMD_W-1:0] lcd_cmd;
  logic                      lcd_cmd_valid;
  logic                      lcd_busy;
  logic                      lcd_done;
  logic                      sched_done;
  logic                      err_illegal;

  // Environment side: requesters and LCD_CTRL.
  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
    input  req0_ready, req1_ready, lcd_cmd, lcd_cmd_valid, sched_done, err_illegal
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
    output req0_ready, req1_ready, lcd_cmd, lcd_cmd_valid, sched_done, err_illegal
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Per-requester command queue; count-based full/empty, head visible combinationally.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_sched.sv
// Round-robin scheduler of two command queues onto LCD_CTRL; a Write ends the session.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  lcd_cmd_sched_if.slave   bus
);

  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]            req_valid, req_ready, legal, push, pop, full, empty;
  logic [NUM_REQ-1:0][CMD_W-1:0] req_cmd, head;

  sched_state_e     state, state_nxt;
  logic             last_grant, grant, issue, port_open, illegal_any;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_vld_q, done_q, err_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_cmd   = {bus.req1_cmd,   bus.req0_cmd};

  // Queues accept only between issues; ready deliberately ignores a same-cycle pop.
  assign port_open = (state == ST_IDLE) || (state == ST_GUARD);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign legal[i]     = cmd_legal(req_cmd[i]);
    assign req_ready[i] = port_open & ~full[i];
    assign push[i]      = req_valid[i] & req_ready[i] & legal[i];
    assign pop[i]       = issue & (grant == 1'(i));

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .wdata (req_cmd[i]),
      .pop   (pop[i]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign illegal_any = |(req_valid & req_ready & ~legal);

  // Contention goes to the requester not served last; otherwise the only non-empty one.
  always_comb begin
    if (!empty[0] && !empty[1]) grant = ~last_grant;
    else                        grant = empty[0];
  end

  assign issue = (state == ST_IDLE) && (|(~empty)) && !bus.lcd_busy;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (issue) state_nxt = (head[grant] == CMD_WRITE) ? ST_WAIT_DONE : ST_GUARD;
      ST_GUARD:     state_nxt = ST_IDLE;
      ST_WAIT_DONE: if (bus.lcd_done) state_nxt = ST_FIN;
      ST_FIN:       state_nxt = ST_FIN;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      cmd_vld_q <= issue;
      err_q     <= illegal_any;
      if (issue) begin
        cmd_q      <= head[grant];
        last_grant <= grant;
      end
      if (state == ST_WAIT_DONE && bus.lcd_done) done_q <= 1'b1;
    end
  end

  assign bus.req0_ready    = req_ready[0];
  assign bus.req1_ready    = req_ready[1];
  assign bus.lcd_cmd       = cmd_q;
  assign bus.lcd_cmd_valid = cmd_vld_q;
  assign bus.sched_done    = done_q;
  assign bus.err_illegal   = err_q;

endmodule
